// File: rtl/muller_c_pkg.sv
// Shared constants for the clocked Muller C-element join: FSM encoding,
// synchroniser depth limit and a constant-width helper.
package muller_c_pkg;

    localparam int SYNC_MAX = 3;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_ACK  = 2'd2;
    localparam logic [1:0] S_REL  = 2'd3;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/muller_c_sync.sv
// N-input clocked C-element behind a SYNC-deep synchroniser chain.
// sync_o exposes the synchronised inputs so the caller can act on them directly.
module muller_c_sync
    import muller_c_pkg::*;
#(
    parameter int N    = 2,
    parameter int SYNC = 2
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic [N-1:0] in_i,
    output logic [N-1:0] sync_o,
    output logic         c_o
);

    localparam int STAGES = (SYNC > SYNC_MAX) ? SYNC_MAX : SYNC;

    generate
        if (STAGES == 0) begin : g_bypass
            assign sync_o = in_i;
        end else begin : g_pipe
            logic [STAGES-1:0][N-1:0] sync_pipe;

            always_ff @(posedge clk_i) begin
                if (reset_i) begin
                    sync_pipe <= '0;
                end else begin
                    sync_pipe[0] <= in_i;
                    for (int s = 1; s < STAGES; s++)
                        sync_pipe[s] <= sync_pipe[s-1];
                end
            end

            assign sync_o = sync_pipe[STAGES-1];
        end
    endgenerate

    // Set on unanimous ones, clear on unanimous zeros, otherwise hold.
    always_ff @(posedge clk_i) begin
        if (reset_i)
            c_o <= 1'b0;
        else if (&sync_o)
            c_o <= 1'b1;
        else if (~|sync_o)
            c_o <= 1'b0;
    end

endmodule

// File: rtl/muller_c_join.sv
// Joins N 4-phase req/ack channels into one downstream 4-phase channel with
// bundled data. Optional watchdog recovery: define MULLER_C_JOIN_TIMEOUT_EN.
module muller_c_join
    import muller_c_pkg::*;
#(
    parameter int N       = 2,
    parameter int W       = 8,
    parameter int SYNC    = 2,
    parameter int TIMEOUT = 1024
) (
    input  logic           clk_i,
    input  logic           reset_i,
    input  logic [N-1:0]   req_i,
    input  logic [N*W-1:0] data_i,
    output logic           ack_o,
    output logic           req_o,
    output logic [N*W-1:0] data_o,
    input  logic           ack_i,
    output logic           c_o,
    output logic           proto_err_o
);

    logic [N-1:0] rs, rs_q;
    logic         as, as_q;
    logic [1:0]   state;
    logic         all_one, all_zero, err_now;

    muller_c_sync #(.N(N), .SYNC(SYNC)) u_req_sync (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .in_i    (req_i),
        .sync_o  (rs),
        .c_o     (c_o)
    );

    // A 1-input C-element is just a one-cycle delay, giving the previous ack.
    muller_c_sync #(.N(1), .SYNC(SYNC)) u_ack_sync (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .in_i    (ack_i),
        .sync_o  (as),
        .c_o     (as_q)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) rs_q <= '0;
        else         rs_q <= rs;
    end

    assign all_one  = &rs;
    assign all_zero = ~|rs;

    assign err_now = ((state == S_REQ) && |(rs_q & ~rs))
                   || (((state == S_REQ) || (state == S_ACK)) && as_q && !as)
                   || ((state == S_IDLE) && as);

`ifdef MULLER_C_JOIN_TIMEOUT_EN
    localparam int CW = clog2(TIMEOUT + 1);
    logic [CW-1:0] to_cnt;
    logic          waiting, to_hit;

    assign waiting = ((state == S_IDLE) && !all_one && !all_zero)
                   || ((state == S_REQ) && !as)
                   || ((state == S_REL) && as);
    // Fires on the TIMEOUT-th consecutive waiting cycle.
    assign to_hit  = waiting && (to_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk_i) begin
        if (reset_i || !waiting || to_hit) to_cnt <= '0;
        else                               to_cnt <= to_cnt + 1'b1;
    end
`endif

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state       <= S_IDLE;
            req_o       <= 1'b0;
            ack_o       <= 1'b0;
            data_o      <= '0;
            proto_err_o <= 1'b0;
        end else begin
            if (err_now) proto_err_o <= 1'b1;
`ifdef MULLER_C_JOIN_TIMEOUT_EN
            if (to_hit) begin
                state       <= S_IDLE;
                req_o       <= 1'b0;
                ack_o       <= 1'b0;
                proto_err_o <= 1'b1;
            end else begin
`else
            begin
`endif
                case (state)
                    S_IDLE: if (all_one) begin
                        req_o  <= 1'b1;
                        data_o <= data_i;
                        state  <= S_REQ;
                    end
                    S_REQ: if (as) begin
                        ack_o <= 1'b1;
                        state <= S_ACK;
                    end
                    S_ACK: if (all_zero) begin
                        req_o <= 1'b0;
                        state <= S_REL;
                    end
                    default: if (!as) begin
                        ack_o <= 1'b0;
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_muller_c_join.sv
// Directed bench for muller_c_join with N=2, W=8, SYNC=2; hand-computed
// expectations checked by immediate assertions.
module tb_muller_c_join;

    localparam int N    = 2;
    localparam int W    = 8;
    localparam int SYNC = 2;
`ifdef MULLER_C_JOIN_TIMEOUT_EN
    localparam int TIMEOUT = 16;
`else
    localparam int TIMEOUT = 1024;
`endif

    logic           clk = 1'b0;
    logic           reset_i;
    logic [N-1:0]   req_i;
    logic [N*W-1:0] data_i;
    logic           ack_o, req_o, ack_i, c_o, proto_err_o;
    logic [N*W-1:0] data_o;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    muller_c_join #(.N(N), .W(W), .SYNC(SYNC), .TIMEOUT(TIMEOUT)) dut (
        .clk_i       (clk),
        .reset_i     (reset_i),
        .req_i       (req_i),
        .data_i      (data_i),
        .ack_o       (ack_o),
        .req_o       (req_o),
        .data_o      (data_o),
        .ack_i       (ack_i),
        .c_o         (c_o),
        .proto_err_o (proto_err_o)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    logic [1:0] hold_seq [7] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b10, 2'b01, 2'b00};
    logic       hold_exp [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

    initial begin
        reset_i = 1'b1; req_i = '0; ack_i = 1'b0; data_i = '0;
        tick(2);
        chk("rst_req_o", req_o, 0);
        chk("rst_ack_o", ack_o, 0);
        chk("rst_c_o", c_o, 0);
        chk("rst_err", proto_err_o, 0);
        chk("rst_data_o", data_o, 0);
        reset_i = 1'b0;

        // Full handshake
        req_i = 2'b01; data_i = 16'hA55A;
        tick(4);
        chk("partial_c_o", c_o, 0);
        chk("partial_req_o", req_o, 0);
        req_i = 2'b11;
        tick(2);
        chk("req_rise_early", req_o, 0);
        tick(1);
        chk("req_rise", req_o, 1);
        chk("data_capture", data_o, 16'hA55A);
        chk("c_rise", c_o, 1);
        ack_i = 1'b1;
        tick(2);
        chk("ack_rise_early", ack_o, 0);
        tick(1);
        chk("ack_rise", ack_o, 1);
        req_i = 2'b00; data_i = '0;
        tick(2);
        chk("req_fall_early", req_o, 1);
        tick(1);
        chk("req_fall", req_o, 0);
        chk("c_fall", c_o, 0);
        ack_i = 1'b0;
        tick(2);
        chk("ack_fall_early", ack_o, 1);
        tick(1);
        chk("ack_fall", ack_o, 0);
        chk("hs_no_err", proto_err_o, 0);
        chk("data_held", data_o, 16'hA55A);

        // C-element hold behaviour (11 then 10 also withdraws a request in S_REQ)
        for (int i = 0; i < 7; i++) begin
            req_i = hold_seq[i];
            tick(3);
            chk($sformatf("hold_c_o_%0d", i), c_o, hold_exp[i]);
            tick(1);
        end
        chk("hold_err", proto_err_o, 1);
        chk("hold_req_o", req_o, 1);

        reset_i = 1'b1;
        tick(1);
        chk("rst2_err", proto_err_o, 0);
        chk("rst2_req_o", req_o, 0);
        chk("rst2_data_o", data_o, 0);
        reset_i = 1'b0;

        // Request withdrawn before ack
        req_i = 2'b11; data_i = 16'h5AA5;
        tick(3);
        chk("pe_req_o", req_o, 1);
        chk("pe_data_o", data_o, 16'h5AA5);
        req_i = 2'b10;
        tick(2);
        chk("pe_err_early", proto_err_o, 0);
        tick(1);
        chk("pe_err", proto_err_o, 1);
        chk("pe_req_held", req_o, 1);
        tick(5);
        chk("pe_err_sticky", proto_err_o, 1);

        reset_i = 1'b1; req_i = 2'b00;
        tick(1);
        reset_i = 1'b0;

        // Ack asserted while idle
        ack_i = 1'b1;
        tick(2);
        chk("idle_ack_err_early", proto_err_o, 0);
        tick(1);
        chk("idle_ack_err", proto_err_o, 1);
        chk("idle_ack_no_ack_o", ack_o, 0);
        ack_i = 1'b0; reset_i = 1'b1;
        tick(1);
        reset_i = 1'b0;

        // Reset in S_ACK
        req_i = 2'b11; data_i = 16'h3CC3;
        tick(3);
        chk("mid_req_o", req_o, 1);
        ack_i = 1'b1;
        tick(3);
        chk("mid_ack_o", ack_o, 1);
        reset_i = 1'b1; ack_i = 1'b0;
        tick(1);
        chk("mid_rst_req_o", req_o, 0);
        chk("mid_rst_ack_o", ack_o, 0);
        chk("mid_rst_data_o", data_o, 0);
        reset_i = 1'b0;
        tick(2);
        chk("restart_early", req_o, 0);
        tick(1);
        chk("restart_req_o", req_o, 1);
        chk("restart_data_o", data_o, 16'h3CC3);
        chk("restart_no_err", proto_err_o, 0);

`ifdef MULLER_C_JOIN_TIMEOUT_EN
        // Waiting for an ack that never comes
        tick(15);
        chk("to_req_early", req_o, 1);
        chk("to_err_early", proto_err_o, 0);
        tick(1);
        chk("to_req_o", req_o, 0);
        chk("to_err", proto_err_o, 1);
        chk("to_ack_o", ack_o, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/muller_c_join.md
Name: muller_c_join

Overview:
- Clocked, parametrised successor to the two-input Muller C-element.
- Joins N independent 4-phase (return-to-zero) request/acknowledge channels into one downstream 4-phase channel, with bundled data.
- Built on an N-input clocked C-element plus a handshake FSM.
- Sits between asynchronous or foreign-clock producers and a synchronous consumer; the SYNC stages make it safe for asynchronous inputs.

Parameters:
- N, 2, number of upstream request channels (2..16)
- W, 8, data width per upstream channel
- SYNC, 2, synchroniser flops on each req_i bit and on ack_i (0..3; 0 = inputs already synchronous)
- TIMEOUT, 1024, watchdog limit in clock cycles (used only with the optional feature)

Ports:
- clk_i  in  1  system clock, rising edge
- reset_i  in  1  synchronous, active-high reset
- req_i  in  N  upstream requests, one per channel
- data_i  in  N*W  bundled data; channel k occupies bits [k*W +: W]; stable while req_i[k]=1
- ack_o  out  1  shared acknowledge to all upstream channels
- req_o  out  1  downstream request
- data_o  out  N*W  captured data, valid while req_o=1
- ack_i  in  1  downstream acknowledge
- c_o  out  1  N-input C-element state, after synchronisation
- proto_err_o  out  1  sticky protocol-violation flag

Behaviour:
- Reset (reset_i=1 at a rising edge):
  - ack_o=0, req_o=0, data_o=0, c_o=0, proto_err_o=0.
  - All synchroniser flops cleared; FSM to S_IDLE.
  - Reset mid-handshake aborts silently; no downstream release phase is generated.
- Reset has priority over every other event in the same cycle.
- Synchronisation: rs = req_i delayed SYNC cycles; as = ack_i delayed SYNC cycles.
- C-element (registered):
  - c_o<=1 when rs is all ones; c_o<=0 when rs is all zeros; otherwise c_o holds.
  - N=2 matches the classic truth table: 00->0, 01/10 hold, 11->1.
- FSM, one transition per cycle max:
  - S_IDLE (req_o=0, ack_o=0): when rs all ones -> req_o<=1, data_o<=data_i, go S_REQ.
  - S_REQ: when as=1 -> ack_o<=1, go S_ACK.
  - S_ACK: when rs all zeros -> req_o<=0, go S_REL.
  - S_REL: when as=0 -> ack_o<=0, go S_IDLE.
- Latency:
  - Last req_i rising to req_o=1: SYNC+1 cycles.
  - ack_i rising to ack_o=1: SYNC+1 cycles.
  - Same latency for the falling edges.
- Mixed rs (some 1, some 0) in S_IDLE or S_ACK: FSM holds; no timeout without the optional feature.
- data_o is captured once, on the S_IDLE->S_REQ transition, and held until the next capture.
- proto_err_o is set (sticky until reset) on any of:
  - any rs bit falling while in S_REQ (request withdrawn before ack);
  - as falling while in S_REQ or S_ACK;
  - as=1 while in S_IDLE.
  The FSM ignores the violation and continues.
- If rs is all ones again immediately in S_IDLE after S_REL, the next cycle starts a new handshake; there are no idle bubbles beyond the state transitions.

Optional Feature:
- Macro MULLER_C_JOIN_TIMEOUT_EN.
- Defined:
  - A counter of clog2(TIMEOUT+1) bits increments every cycle the FSM stays in S_IDLE with mixed rs, or in S_REQ/S_REL waiting on as.
  - It clears on any state change.
  - On reaching TIMEOUT it sets proto_err_o and forces the FSM to S_IDLE with req_o=0 and ack_o=0.
- Not defined: no counter and no forced recovery; waits are unbounded.

Decomposition:
- Shared package muller_c_pkg:
  - state encoding constants S_IDLE=2'd0, S_REQ=2'd1, S_ACK=2'd2, S_REL=2'd3;
  - function clog2;
  - SYNC_MAX=3.
- Natural sub-module: muller_c_sync, the N-input clocked C-element including its synchroniser chain (params N, SYNC; ports clk_i, reset_i, in_i, c_o). Instantiated once for req_i; ack_i uses a 1-bit instance.

Test Plan (N=2, W=8, SYNC=2):
- Reset then idle: reset_i=1 for 2 cycles, req_i=00 -> req_o=0, ack_o=0, c_o=0, proto_err_o=0.
- Full handshake:
  - req_i=01 then 11, data_i=16'hA55A -> req_o=1 exactly 3 cycles after 11, data_o=16'hA55A.
  - ack_i=1 -> ack_o=1 3 cycles later.
  - req_i=00 -> req_o=0 3 cycles later.
  - ack_i=0 -> ack_o=0 3 cycles later.
- Hold behaviour: sequence req_i 00,01,10,11,10,01,00 -> c_o follows 0,0,0,1,1,1,0, each delayed 3 cycles.
- Protocol error: in S_REQ drop req_i to 10 before ack_i -> proto_err_o=1 and stays 1; req_o stays 1.
- Reset mid-operation: assert reset_i in S_ACK -> next edge req_o=0, ack_o=0; with req_i=11 held after release, req_o=1 3 cycles later.
- With MULLER_C_JOIN_TIMEOUT_EN, TIMEOUT=16: req_o=1, ack_i held 0 -> after 16 cycles proto_err_o=1, req_o=0, FSM in S_IDLE.
